// File: rtl/comparator_sequencer_pkg.sv
// Shared types and constants for the comparator sequencer: FSM encoding,
// code range and the width of the match counter.
package comparator_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [1:0] CODE_FIRST = 2'd0;
  localparam logic [1:0] CODE_LAST  = 2'd3;

  localparam int MATCH_CNT_W  = 3;
  localparam int SETTLE_CNT_W = 3;

  typedef logic [MATCH_CNT_W-1:0] match_cnt_t;

endpackage

// File: rtl/comparator_sequencer_if.sv
// Control, comparator and result signals of the comparator sequencer.
// The sequencer is the slave; whoever issues start and models the comparator is the master.
interface comparator_sequencer_if;
  import comparator_sequencer_pkg::*;

  logic             start;
  logic             mode;
  logic [1:0]       code_in;
  logic             abort;
  logic [1:0]       s_out;
  logic             k_in;
  logic             l_in;
  logic             busy;
  logic             done;
  logic [3:0]       k_vec;
  logic [3:0]       l_vec;
  match_cnt_t       match_cnt;
  logic             err;

  modport slave (
    input  start, mode, code_in, abort, k_in, l_in,
    output s_out, busy, done, k_vec, l_vec, match_cnt, err
  );

  modport master (
    output start, mode, code_in, abort, k_in, l_in,
    input  s_out, busy, done, k_vec, l_vec, match_cnt, err
  );

endinterface

// File: rtl/comparator_sequencer_settle_counter.sv
// Settle countdown: load a cycle count, decrement once per DRIVE cycle, and flag
// the decrement that brings the count to zero so the FSM can leave DRIVE on that edge.
module seq_settle_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // NOTE: always_comb gives every output a default first so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == W'(1));

endmodule

// File: rtl/comparator_sequencer.sv
// Sequences select codes onto an external comparator, lets each settle, and
// captures its K/L outputs per code into result vectors with a match count.
module comparator_sequencer
  import comparator_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  comparator_sequencer_if.slave bus
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_VAL = SETTLE_CNT_W'(SETTLE);

  state_t     state_q, state_d;
  logic [1:0] code_q, code_d;
  logic       mode_q, mode_d;
  logic [3:0] k_vec_q, k_vec_d;
  logic [3:0] l_vec_q, l_vec_d;
  match_cnt_t match_cnt_q, match_cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic       cnt_load;
  logic       cnt_dec;
  logic       cnt_zero;

  seq_settle_counter #(.W(SETTLE_CNT_W)) u_settle (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (SETTLE_VAL),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    mode_d      = mode_q;
    k_vec_d     = k_vec_q;
    l_vec_d     = l_vec_q;
    match_cnt_d = match_cnt_q;
    err_d       = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start && !bus.abort) begin
          state_d     = DRIVE;
          mode_d      = bus.mode;
          code_d      = bus.mode ? CODE_FIRST : bus.code_in;
          k_vec_d     = '0;
          l_vec_d     = '0;
          match_cnt_d = '0;
          cnt_load    = 1'b1;
        end
      end
      DRIVE: begin
        err_d = bus.start;
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          cnt_dec = 1'b1;
          if (cnt_zero) state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        err_d = bus.start;
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          k_vec_d[code_q] = bus.k_in;
          l_vec_d[code_q] = bus.l_in;
          if (bus.k_in == bus.l_in) match_cnt_d = match_cnt_q + match_cnt_t'(1);
          // Sweep stops at CODE_LAST; the rollover to CODE_FIRST only happens on the next accept.
          if (mode_q && (code_q != CODE_LAST)) begin
            code_d   = code_q + 2'd1;
            cnt_load = 1'b1;
            state_d  = DRIVE;
          end else begin
            state_d = DONE;
          end
        end
      end
    endcase

    busy_d = (state_d == DRIVE) || (state_d == SAMPLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      code_q      <= CODE_FIRST;
      mode_q      <= 1'b0;
      k_vec_q     <= '0;
      l_vec_q     <= '0;
      match_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      mode_q      <= mode_d;
      k_vec_q     <= k_vec_d;
      l_vec_q     <= l_vec_d;
      match_cnt_q <= match_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.s_out     = code_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.k_vec     = k_vec_q;
  assign bus.l_vec     = l_vec_q;
  assign bus.match_cnt = match_cnt_q;

endmodule
